mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle main control FSM for the teaching CPU; sits directly upstream of aludec.
//  Sequences fetch/decode/execute/memory/writeback from the 4-bit opcode and drives datapath enables.
//  Supplies aluop[1:0] to aludec, which combines it with funct[3:0] to form alucontrol[2:0].
//  Memory accesses use a req/ready handshake, so the FSM stalls on slow memory.
// PARAMETERS
//  OPW  4  opcode width; only 4 is supported
// PORTS
//  clk        in   1  single system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  opcode     in   4  instr[15:12] from instruction register; sampled only in DECODE
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access request; held until mem_ready
//  iord       out  1  0=PC address, 1=ALUOut address
//  memwrite   out  1  store strobe, qualified by mem_req
//  irwrite    out  1  load instruction register
//  pcwrite    out  1  unconditional PC write
//  branch     out  1  PC write if ALU zero
//  regwrite   out  1  register file write
//  regdst     out  1  0=rt, 1=rd destination
//  memtoreg   out  1  0=ALUOut, 1=MDR writeback
//  alusrca    out  1  0=PC, 1=regA
//  alusrcb    out  2  00=regB 01=const 1 10=signext imm
//  pcsrc      out  2  00=ALU 01=ALUOut 10=jump target
//  aluop      out  2  00=add 01=sub 10=use funct; 11 never driven
//  illegal    out  1  sticky: undefined opcode decoded
//  state_o    out  4  current state encoding, for debug and bench
// BEHAVIOUR
//  Reset: async, active-low. State goes to FETCH, illegal=0. Every output is forced 0 while rst_n=0.
//  First FETCH cycle starts on the first clk edge after rst_n deasserts.
//  Reset mid-instruction aborts it. No partial regwrite/memwrite occurs after rst_n falls.
//  Outputs are Moore: decoded from state only, except the pulses noted below.
//  Opcodes: RTYPE=0000 LW=0001 SW=0010 BEQ=0011 ADDI=0100 J=0101; 0110-1111 are illegal.
//  FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
//    irwrite=pcwrite=1 only in the cycle mem_ready=1 (Mealy pulse); that cycle advances to DECODE.
//    While mem_ready=0, stay in FETCH with no PC/IR write.
//  DECODE: alusrca=0, alusrcb=10, aluop=00 (branch target precompute).
//    Next state: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, else->TRAP.
//  MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: LW->MEMRD, SW->MEMWR.
//  MEMRD: mem_req=1, iord=1. Advance to MEMWB on mem_ready.
//  MEMWB: regwrite=1, regdst=0, memtoreg=1. Next: FETCH.
//  MEMWR: mem_req=1, iord=1, memwrite=1. Advance to FETCH on mem_ready.
//  EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
//  ALUWB: regwrite=1, regdst=1, memtoreg=0. Next: FETCH.
//  BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01. Next: FETCH.
//  ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
//  ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next: FETCH.
//  JUMP: pcwrite=1, pcsrc=10. Next: FETCH.
//  TRAP: illegal=1; all enables 0; terminal state, left only by reset.
//  Cycles per instruction with zero-wait memory (mem_ready=1 throughout):
//    RTYPE=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3.
//    Each memory wait cycle adds exactly 1 cycle.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  opcode changes outside DECODE have no effect.
//  Unused state encodings recover to FETCH on the next clock.
// STRUCTURE
//  ctrl_pkg holds:
//    state_t enum (4-bit): FETCH..TRAP
//    opcode localparams
//    ALUOP_ADD/SUB/FUNCT constants (shared with aludec)
//    ALUSRCB_* and PCSRC_* constants
//  Single module; no sub-modules. Implemented as a state register plus a combinational next-state/output block.
// TESTING
//  1. rst_n=0 held 3 clks -> all outputs 0; release -> state_o=FETCH, mem_req=1.
//  2. RTYPE, mem_ready=1 -> 4 cycles.
//     aluop=10 in EXECUTE; regwrite=1, regdst=1 in cycle 4; then FETCH.
//  3. LW, mem_ready low 2 cycles in MEMRD -> 7 cycles total.
//     memtoreg=1 and regwrite pulses exactly once.
//  4. SW -> memwrite=1 only in MEMWR; regwrite never 1.
//     BEQ -> aluop=01, branch=1 in cycle 3.
//  5. Opcode 1001 -> TRAP, illegal=1 held 10 clks; rst_n pulse -> illegal=0, FETCH.
//  6. rst_n asserted mid-MEMWR (async, between edges) -> memwrite drops immediately.
//     After release, FETCH resumes with no write.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle control FSM
// (mc_controller) and the ALU decoder downstream of it (aludec).
//   state_t    : 4-bit FSM state encoding, FETCH..TRAP
//   OP_*       : 4-bit opcodes (instr[15:12])
//   ALUOP_*    : aluop codes consumed by aludec
//   ALUSRCB_*  : ALU B-operand select codes
//   PCSRC_*    : next-PC select codes
//   ctrl_t     : bundle of all datapath control outputs
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB = 2'b00;
  localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_controller.sv
// mc_controller: multicycle main control FSM for the teaching CPU.
// Sequences fetch/decode/execute/memory/writeback from the opcode and
// drives the datapath enables; memory accesses stall on a req/ready
// handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   opcode[OPW-1:0]       instr[15:12], sampled only in DECODE
//   mem_ready             memory completes the current access
//   mem_req, iord, memwrite, irwrite, pcwrite, branch, regwrite,
//   regdst, memtoreg, alusrca, alusrcb[1:0], pcsrc[1:0], aluop[1:0]
//                         datapath controls (Moore, except the FETCH
//                         irwrite/pcwrite pulse which follows mem_ready)
//   illegal               sticky: undefined opcode decoded (TRAP state)
//   state_o[3:0]          current state encoding
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           branch,
  output logic           regwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [1:0]     aluop,
  output logic           illegal,
  output logic [3:0]     state_o
);

  state_t state_reg;
  state_t state_next;
  // run_reg holds the FSM idle until the first clock edge after reset is
  // released, so the first real FETCH cycle begins on that edge.
  logic   run_reg;
  // LW vs SW is captured in DECODE because opcode is only valid there;
  // MEMADR needs it one cycle later.
  logic   is_lw_reg;
  ctrl_t  ctrl;
  logic   out_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
      run_reg   <= 1'b0;
      is_lw_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (run_reg) begin
        state_reg <= state_next;
      end
      if (run_reg && state_reg == DECODE) begin
        is_lw_reg <= (opcode == OP_LW);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR:  state_next = is_lw_reg ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_next = MEMWB;
      MEMWB:   state_next = FETCH;
      MEMWR:   if (mem_ready) state_next = FETCH;
      EXECUTE: state_next = ALUWB;
      ALUWB:   state_next = FETCH;
      BRANCH:  state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JUMP:    state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;  // unused encodings recover
    endcase
  end

  // Output decode
  always_comb begin
    ctrl = '0;
    case (state_reg)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = ALUSRCB_ONE;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        // PC/IR load only on the cycle the instruction word arrives.
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_REGB;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PCSRC_ALUOUT;
      end
      ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PCSRC_JUMP;
      end
      TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // rst_n gates the outputs combinationally so a store or register write
  // in progress is cut off the instant reset is asserted, not at the
  // next edge.
  assign out_en = rst_n & run_reg;

  assign mem_req  = out_en & ctrl.mem_req;
  assign iord     = out_en & ctrl.iord;
  assign memwrite = out_en & ctrl.memwrite;
  assign irwrite  = out_en & ctrl.irwrite;
  assign pcwrite  = out_en & ctrl.pcwrite;
  assign branch   = out_en & ctrl.branch;
  assign regwrite = out_en & ctrl.regwrite;
  assign regdst   = out_en & ctrl.regdst;
  assign memtoreg = out_en & ctrl.memtoreg;
  assign alusrca  = out_en & ctrl.alusrca;
  assign alusrcb  = out_en ? ctrl.alusrcb : 2'b00;
  assign pcsrc    = out_en ? ctrl.pcsrc   : 2'b00;
  assign aluop    = out_en ? ctrl.aluop   : 2'b00;
  assign illegal  = out_en & ctrl.illegal;
  assign state_o  = rst_n ? state_reg : FETCH;

endmodule
